tx_gearbox_feeder: RTL and testbench
====================================

// Module: tx_gearbox_feeder
// PURPOSE
//  Parametrised TX PCS back-end. Buffers scrambled 64b/66b blocks in a small FIFO.
//  Drives the GTH external-sequence gearbox: OUT_W-bit data words, 2-bit header and TXSEQUENCE.
//  Sits between the scrambler and the transceiver. Generalises the fixed 32-bit TX path:
//  selectable width, optional bit reversal, elastic buffering with backpressure, underrun fill and status.
// PARAMETERS
//  OUT_W      32            transceiver data width; legal values 32 or 64
//  DEPTH      8             FIFO depth in 66b blocks; power of two, 4..64
//  BIT_REV    1             1: bit-reverse data[63:0] and head[1:0] before output; 0: pass through
//  FILL_DATA  64'h1E...     payload emitted on underrun; head is 2'b10 (default: control block, idle type 0x1E)
// PORTS
//  clk_i           in   1        transceiver TX user clock
//  rst_n_i         in   1        asynchronous, active-low reset
//  blk_data_i      in   64       scrambled block payload
//  blk_head_i      in   2        sync header (01 data / 10 control)
//  blk_valid_i     in   1        block present on blk_*_i
//  blk_ready_o     out  1        FIFO can accept a block this cycle
//  data_o          out  OUT_W    TXDATA to gearbox
//  head_o          out  6        TXHEADER; [5:2] = 0, [1:0] = header
//  sequence_o      out  7        TXSEQUENCE; [6] = 0
//  underrun_o      out  1        1-cycle pulse: fill block emitted
//  fifo_level_o    out  $clog2(DEPTH)+1  blocks currently stored
//  underrun_cnt_o  out  16       saturating underrun count
//  clr_cnt_i       in   1        synchronous clear of underrun_cnt_o
// BEHAVIOUR
//  - Reset: all outputs 0 except blk_ready_o = 1 (one cycle after deassert); FIFO empty; phase counter cnt = 0.
//  - Reset mid-operation: FIFO contents are discarded; cnt restarts at 0.
//  - WORDS = 64/OUT_W; CNT_MAX = 33*WORDS-1; cnt increments every cycle and wraps CNT_MAX -> 0.
//  - Sequence: seq = cnt/WORDS (0..32).
//  - Consume slot: (cnt % WORDS == 0) && seq < 32. This gives 32 blocks per 33 sequence periods.
//  - Pause: seq == 32 for WORDS cycles. data_o and head_o hold their last value; no pop.
//  - Input handshake: push when blk_valid_i && blk_ready_o; blk_ready_o = !full (registered-level, no comb path from pop).
//  - Pop: at a consume slot if FIFO not empty. No same-cycle push-to-pop bypass.
//  - Push and pop in the same cycle: level unchanged.
//  - Full: blk_ready_o = 0; upstream holds its block. Overflow is impossible by construction.
//  - Underrun: consume slot with FIFO empty -> emit FILL_DATA with head 2'b10 (before BIT_REV).
//    underrun_o pulses together with the first word; underrun_cnt_o += 1, saturating at 16'hFFFF.
//  - clr_cnt_i has priority over a same-cycle increment.
//  - Output word k (k = 0..WORDS-1) of block B:
//    data_o = R[63-OUT_W*k -: OUT_W], with R = BIT_REV ? rev64(B.data) : B.data.
//    head_o[1:0] = BIT_REV ? rev2(B.head) : B.head. head_o is updated only with word 0 and held otherwise.
//  - Latency: consume slot at cycle t -> word 0 on data_o at t+1, word k at t+1+k.
//    sequence_o is delayed to match: sequence_o at t+1 = seq(t).
//  - fifo_level_o is registered; it reflects the push/pop of the previous cycle.
// STRUCTURE
//  - Shared package/include (xgmii_includes.vh): bit64_rev, bit2_rev, HDR_DATA=2'b01, HDR_CTRL=2'b10,
//    SEQ_PAUSE=32, default FILL_DATA.
//  - Sub-module tx_blk_fifo: 66b wide, DEPTH deep, synchronous FIFO.
//    Async active-low reset; ports push/pop/full/empty/level.
//  - Top-level contents: phase counter, consume-slot decode, output shift register, sequence delay, status counters.
// TESTING
//  - OUT_W=32: continuous valid blocks, incrementing payload.
//    -> seq 0,0,1,1..31,31,32,32,0; 32 pops per 66 cycles; no underrun.
//  - Pause check: blocks available but seq==32.
//    -> no pop; data_o/head_o held; blk_ready_o deasserts once level hits DEPTH.
//  - Empty FIFO at a consume slot, BIT_REV=0.
//    -> data_o = FILL_DATA[63:32] then [31:0]; head_o = 6'h02; underrun_o 1 cycle; underrun_cnt_o = 1.
//  - BIT_REV=1, block data=64'h1, head=2'b01.
//    -> word0 = 32'h8000_0000, word1 = 0, head_o = 6'h02.
//  - OUT_W=64: seq 0..32 then wraps; 64-bit word per block; fill data handled at the 64-bit width.
//  - Assert rst_n_i mid-frame with level=5.
//    -> outputs 0 asynchronously; level=0; after release seq restarts at 0; first slot underruns.

Source files
------------

// File: rtl/tx_gearbox_feeder_pkg.sv
// Shared types and helpers for the TX gearbox feeder.
// Header codes, pause sequence and bit-reversal functions.
package tx_gearbox_feeder_pkg;

  localparam logic [1:0]  HDR_DATA     = 2'b01;
  localparam logic [1:0]  HDR_CTRL     = 2'b10;
  localparam int          SEQ_PAUSE    = 32;
  localparam logic [63:0] FILL_DEFAULT = 64'h1E00_0000_0000_0000;

  typedef struct packed {
    logic [1:0]  head;
    logic [63:0] data;
  } blk_t;

  function automatic logic [63:0] bit64_rev(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  function automatic logic [1:0] bit2_rev(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/tx_gearbox_feeder_fifo.sv
// Synchronous 66b block FIFO with registered level.
// Caller guarantees no push when full and no pop when empty.
module tx_blk_fifo
  import tx_gearbox_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  blk_t                   wdata,
  input  logic                   pop,
  output blk_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  blk_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/tx_gearbox_feeder.sv
// TX PCS back-end: buffers 66b blocks and feeds the
// external-sequence gearbox with data, header and sequence.
module tx_gearbox_feeder
  import tx_gearbox_feeder_pkg::*;
#(
  parameter int          OUT_W     = 32,
  parameter int          DEPTH     = 8,
  parameter bit          BIT_REV   = 1'b1,
  parameter logic [63:0] FILL_DATA = FILL_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [63:0]            blk_data_i,
  input  logic [1:0]             blk_head_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  output logic [OUT_W-1:0]       data_o,
  output logic [5:0]             head_o,
  output logic [6:0]             sequence_o,
  output logic                   underrun_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [15:0]            underrun_cnt_o,
  input  logic                   clr_cnt_i
);

  localparam int WORDS   = 64 / OUT_W;
  localparam int CNT_MAX = 33 * WORDS - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    seq;
  logic [CW-1:0]    wrd;
  logic             active;
  logic             slot;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             rdy_en;
  blk_t             wr_blk;
  blk_t             rd_blk;
  blk_t             src;
  logic [63:0]      rdat;
  logic [1:0]       rhd;
  logic [OUT_W-1:0] data_q;
  logic [63:0]      blk_q;
  logic [1:0]       head_q;
  logic [5:0]       seq_q;
  logic             underrun_q;
  logic [15:0]      ucnt;

  assign seq    = cnt / CW'(WORDS);
  assign wrd    = cnt % CW'(WORDS);
  assign active = (seq < CW'(SEQ_PAUSE));
  assign slot   = active && (wrd == '0);

  // Ready comes only from registered state, never from this cycle's pop.
  assign blk_ready_o = rdy_en && !full;
  assign push        = blk_valid_i && blk_ready_o;
  assign pop         = slot && !empty;
  assign wr_blk      = {blk_head_i, blk_data_i};

  tx_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push),
    .wdata (wr_blk),
    .pop   (pop),
    .rdata (rd_blk),
    .full  (full),
    .empty (empty),
    .level (fifo_level_o)
  );

  always_comb begin
    src = rd_blk;
    if (empty) begin
      src.head = HDR_CTRL;
      src.data = FILL_DATA;
    end
    rdat = BIT_REV ? bit64_rev(src.data) : src.data;
    rhd  = BIT_REV ? bit2_rev(src.head) : src.head;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt        <= '0;
      rdy_en     <= 1'b0;
      data_q     <= '0;
      blk_q      <= '0;
      head_q     <= '0;
      seq_q      <= '0;
      underrun_q <= 1'b0;
      ucnt       <= '0;
    end else begin
      cnt        <= (cnt == CW'(CNT_MAX)) ? '0 : cnt + CW'(1);
      rdy_en     <= 1'b1;
      seq_q      <= 6'(seq);
      underrun_q <= slot && empty;
      // Pause cycles fall through both branches and hold the outputs.
      if (slot) begin
        data_q <= rdat[63 -: OUT_W];
        blk_q  <= rdat;
        head_q <= rhd;
      end else if (active) begin
        data_q <= blk_q[63 - OUT_W * int'(wrd) -: OUT_W];
      end
      if (clr_cnt_i)
        ucnt <= '0;
      else if (slot && empty && ucnt != 16'hFFFF)
        ucnt <= ucnt + 16'd1;
    end
  end

  assign data_o         = data_q;
  assign head_o         = {4'b0000, head_q};
  assign sequence_o     = {1'b0, seq_q};
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt;

endmodule

// File: tb/tb_tx_gearbox_feeder.sv
// Bench: three feeder configurations driven by shared random stimulus,
// checked every cycle against a queue-based block model.
module tb_tx_gearbox_feeder;

  localparam logic [63:0] FILL = 64'h1E00_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] bdata;
  logic [1:0]  bhead;
  logic        bvalid;
  logic        clr;

  logic        r0, r1, r2;
  logic [31:0] d0, d1;
  logic [63:0] d2;
  logic [5:0]  h0, h1, h2;
  logic [6:0]  s0, s1, s2;
  logic        ur0, ur1, ur2;
  logic [3:0]  l0;
  logic [2:0]  l1, l2;
  logic [15:0] c0, c1, c2;

  tx_gearbox_feeder #(.OUT_W(32), .DEPTH(8), .BIT_REV(1'b0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .blk_data_i(bdata), .blk_head_i(bhead),
    .blk_valid_i(bvalid), .blk_ready_o(r0), .data_o(d0), .head_o(h0),
    .sequence_o(s0), .underrun_o(ur0), .fifo_level_o(l0),
    .underrun_cnt_o(c0), .clr_cnt_i(clr));

  tx_gearbox_feeder #(.OUT_W(32), .DEPTH(4), .BIT_REV(1'b1)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .blk_data_i(bdata), .blk_head_i(bhead),
    .blk_valid_i(bvalid), .blk_ready_o(r1), .data_o(d1), .head_o(h1),
    .sequence_o(s1), .underrun_o(ur1), .fifo_level_o(l1),
    .underrun_cnt_o(c1), .clr_cnt_i(clr));

  tx_gearbox_feeder #(.OUT_W(64), .DEPTH(4), .BIT_REV(1'b0)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .blk_data_i(bdata), .blk_head_i(bhead),
    .blk_valid_i(bvalid), .blk_ready_o(r2), .data_o(d2), .head_o(h2),
    .sequence_o(s2), .underrun_o(ur2), .fifo_level_o(l2),
    .underrun_cnt_o(c2), .clr_cnt_i(clr));

  int passed = 0;
  int total  = 0;

  // Model state, one slot per instance
  int          cnt_m [3];
  int          lvl_m [3];
  bit          rdy_m [3];
  logic [65:0] q_m   [3][64];
  int          hd_m  [3];
  int          tl_m  [3];
  logic [63:0] cur_m [3];
  logic [63:0] exd   [3];
  logic [1:0]  exh   [3];
  int          exs   [3];
  bit          exu   [3];
  int          exc   [3];

  function automatic int ow_of(int i);
    return (i == 2) ? 64 : 32;
  endfunction

  function automatic int dp_of(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic bit rv_of(int i);
    return (i == 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      cnt_m[i] = 0; lvl_m[i] = 0; rdy_m[i] = 1'b0;
      hd_m[i] = 0; tl_m[i] = 0; cur_m[i] = '0;
      exd[i] = '0; exh[i] = '0; exs[i] = 0; exu[i] = 1'b0; exc[i] = 0;
    end
  endtask

  // One clock edge of the reference: block queue plus phase arithmetic.
  task automatic medge();
    int w, c, sq, ow;
    bit slot, push, pop;
    logic [65:0] b;
    logic [63:0] rd;
    logic [1:0]  rh;
    for (int i = 0; i < 3; i++) begin
      ow = ow_of(i);
      w = 64 / ow;
      c = cnt_m[i];
      sq = c / w;
      slot = (c % w == 0) && (sq < 32);
      push = bvalid && rdy_m[i];
      pop = slot && (lvl_m[i] > 0);
      exu[i] = 1'b0;
      if (slot) begin
        if (pop) begin
          b = q_m[i][hd_m[i]];
          hd_m[i] = (hd_m[i] + 1) % 64;
        end else begin
          b = {2'b10, FILL};
        end
        rd = {<<{b[63:0]}};
        rh = {<<{b[65:64]}};
        cur_m[i] = rv_of(i) ? rd : b[63:0];
        exh[i] = rv_of(i) ? rh : b[65:64];
        exu[i] = !pop;
        if (!pop && exc[i] < 65535) exc[i]++;
      end
      if (clr) exc[i] = 0;
      if (sq < 32) exd[i] = (cur_m[i] << (ow * (c % w))) >> (64 - ow);
      exs[i] = sq;
      if (push) begin
        q_m[i][tl_m[i]] = {bhead, bdata};
        tl_m[i] = (tl_m[i] + 1) % 64;
      end
      lvl_m[i] = lvl_m[i] + int'(push) - int'(pop);
      rdy_m[i] = (lvl_m[i] < dp_of(i));
      cnt_m[i] = (c + 1) % (33 * w);
    end
  endtask

  task automatic chk();
    logic [63:0] od [3];
    logic [63:0] oh [3];
    logic [63:0] os [3];
    logic [63:0] ou [3];
    logic [63:0] ol [3];
    logic [63:0] oc [3];
    logic [63:0] orr [3];
    od[0] = 64'(d0); od[1] = 64'(d1); od[2] = d2;
    oh[0] = 64'(h0); oh[1] = 64'(h1); oh[2] = 64'(h2);
    os[0] = 64'(s0); os[1] = 64'(s1); os[2] = 64'(s2);
    ou[0] = 64'(ur0); ou[1] = 64'(ur1); ou[2] = 64'(ur2);
    ol[0] = 64'(l0); ol[1] = 64'(l1); ol[2] = 64'(l2);
    oc[0] = 64'(c0); oc[1] = 64'(c1); oc[2] = 64'(c2);
    orr[0] = 64'(r0); orr[1] = 64'(r1); orr[2] = 64'(r2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("data%0d", i), od[i], exd[i]);
      check($sformatf("head%0d", i), oh[i], 64'(exh[i]));
      check($sformatf("seq%0d", i), os[i], 64'(exs[i]));
      check($sformatf("underrun%0d", i), ou[i], 64'(exu[i]));
      check($sformatf("level%0d", i), ol[i], 64'(lvl_m[i]));
      check($sformatf("ucnt%0d", i), oc[i], 64'(exc[i]));
      check($sformatf("ready%0d", i), orr[i], 64'(rdy_m[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    medge();
    #1;
    chk();
  endtask

  initial begin
    bvalid = 1'b0; bdata = '0; bhead = '0; clr = 1'b0;
    mreset();
    #12;
    chk();
    rst_n = 1'b1;

    // First slot after reset underruns
    step();
    check("fill_w0", 64'(d0), 64'h1E00_0000);
    check("fill_head", 64'(h0), 64'h02);
    check("fill_pulse", 64'(ur0), 64'd1);
    check("fill_cnt", 64'(c0), 64'd1);
    step();
    check("fill_w1", 64'(d0), 64'h0);
    check("fill_pulse_end", 64'(ur0), 64'd0);
    repeat (3) step();

    // Single data block 64'h1 with data header
    bvalid = 1'b1; bdata = 64'h1; bhead = 2'b01;
    step();
    bvalid = 1'b0;
    repeat (8) step();

    // Continuous valid: FIFOs fill, pause and backpressure
    bvalid = 1'b1;
    repeat (300) begin
      bdata = {$urandom, $urandom};
      bhead = 2'($urandom_range(1, 2));
      step();
    end

    // Sparse traffic with occasional counter clears
    repeat (400) begin
      bvalid = ($urandom_range(0, 9) < 4);
      bdata = {$urandom, $urandom};
      bhead = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 1'b0;

    // Bring instance 0 to level 5, then reset mid-frame
    for (int n = 0; n < 400; n++) begin
      if (lvl_m[0] == 5) break;
      bvalid = (lvl_m[0] < 5);
      bdata = {$urandom, $urandom};
      bhead = 2'b01;
      step();
    end
    check("pre_reset_level", 64'(l0), 64'd5);
    bvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk();
    #10;
    rst_n = 1'b1;
    step();
    check("post_reset_underrun", 64'(ur0), 64'd1);
    check("post_reset_seq", 64'(s0), 64'd0);
    repeat (150) begin
      bvalid = ($urandom_range(0, 1) == 1);
      bdata = {$urandom, $urandom};
      bhead = 2'($urandom_range(1, 2));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
